microseq_ctrl: RTL and testbench

- Parametrised, programmable microsequencer driving a datapath (multipliers, dividers and similar) from a writable control store.
- Each cycle it emits a control word and picks the next micro-PC from a selectable, optionally inverted condition.
- Supports micro-subroutine CALL/RET via a bounded return stack, a start/busy/done handshake and a sticky error flag.
- Next generation of the fixed-ROM, fixed-done-address control units: width, depth, condition count and stack depth are all parameters.

---
 rtl/microseq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_microseq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
// ---------------------------------------------------------------------------
// microseq_ctrl
//
// Programmable microsequencer. A writable control store holds
// microinstructions of the form {op, inv, sel, target, ctrl} (MSB..LSB).
// While running, one microinstruction executes per cycle. Its ctrl field
// drives the datapath, and the next micro-PC is chosen from a selectable,
// optionally inverted condition. CALL/RET use a bounded return stack.
//
// Handshake: start is accepted only in IDLE (busy=0). busy is high for
// exactly the cycles in which c carries a valid control word. done and err
// are sticky until the next accepted start or reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin execution at START_ADDR (ignored while busy)
//   cond       datapath condition flags, used combinationally
//   prog_we    control-store write enable (ignored while busy)
//   prog_addr  control-store write address
//   prog_data  microinstruction to write
//   c          control word (0 when idle)
//   busy       high while running
//   done       sticky: program reached a taken HALT
//   err        sticky: return-stack overflow or underflow
//   upc        current micro-PC (debug)
// ---------------------------------------------------------------------------
module microseq_ctrl #(
    parameter int UPC_W      = 5,
    parameter int CTRL_W     = 15,
    parameter int NCOND      = 4,
    parameter int STACK_D    = 2,
    parameter int START_ADDR = 0,
    localparam int CS_W      = $clog2(NCOND + 2),
    localparam int UI_W      = CTRL_W + UPC_W + CS_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NCOND-1:0]  cond,
    input  logic              prog_we,
    input  logic [UPC_W-1:0]  prog_addr,
    input  logic [UI_W-1:0]   prog_data,
    output logic [CTRL_W-1:0] c,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [UPC_W-1:0]  upc
);

    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int DEPTH = 2 ** UPC_W;

    localparam logic [1:0] OP_JMP  = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state;

    // Control store: asynchronous read, synchronous write, never cleared.
    logic [UI_W-1:0] cs_mem [DEPTH];

    // The stack array is padded to a power of two so that sp indexes it
    // at its natural width; only the first STACK_D entries are ever used.
    logic [UPC_W-1:0] stack_mem [2 ** SP_W];
    logic [SP_W-1:0]  sp;

    logic [UI_W-1:0]   ui;
    logic [CTRL_W-1:0] f_ctrl;
    logic [UPC_W-1:0]  f_target;
    logic [CS_W-1:0]   f_sel;
    logic              f_inv;
    logic [1:0]        f_op;
    logic              sel_v;
    logic              br;
    logic [UPC_W-1:0]  upc_inc;

    assign ui       = cs_mem[upc];
    assign f_ctrl   = ui[CTRL_W-1:0];
    assign f_target = ui[CTRL_W +: UPC_W];
    assign f_sel    = ui[CTRL_W+UPC_W +: CS_W];
    assign f_inv    = ui[CTRL_W+UPC_W+CS_W];
    assign f_op     = ui[UI_W-1 -: 2];

    // sel=0 -> 0, sel=1 -> 1, sel=k+2 -> cond[k]; out-of-range selects 0.
    always_comb begin
        sel_v = 1'b0;
        if (f_sel == CS_W'(1)) begin
            sel_v = 1'b1;
        end
        for (int k = 0; k < NCOND; k++) begin
            if (f_sel == CS_W'(k + 2)) begin
                sel_v = cond[k];
            end
        end
    end

    assign br      = sel_v ^ f_inv;
    assign upc_inc = upc + UPC_W'(1);   // wraps naturally from all-ones to 0

    assign busy = (state == S_RUN);
    assign c    = busy ? f_ctrl : '0;

    // Writes are gated by the registered busy, so a write in the same IDLE
    // cycle as start lands before the first fetch.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            cs_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            upc   <= UPC_W'(START_ADDR);
            sp    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        upc   <= UPC_W'(START_ADDR);
                        sp    <= '0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end

                S_RUN: begin
                    case (f_op)
                        OP_JMP: begin
                            upc <= br ? f_target : upc_inc;
                        end

                        OP_CALL: begin
                            if (!br) begin
                                upc <= upc_inc;
                            end else if (sp == SP_W'(STACK_D)) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                stack_mem[sp] <= upc_inc;
                                sp            <= sp + SP_W'(1);
                                upc           <= f_target;
                            end
                        end

                        OP_RET: begin
                            if (!br) begin
                                upc <= upc_inc;
                            end else if (sp == '0) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                sp  <= sp - SP_W'(1);
                                upc <= stack_mem[sp - SP_W'(1)];
                            end
                        end

                        default: begin  // OP_HALT
                            if (!br) begin
                                upc <= upc_inc;
                            end else begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    endcase
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microseq_ctrl.sv
module tb_microseq_ctrl;

    localparam int UPC_W   = 5;
    localparam int CTRL_W  = 15;
    localparam int NCOND   = 4;
    localparam int STACK_D = 2;
    localparam int START   = 0;
    localparam int CS_W    = 3;
    localparam int UI_W    = CTRL_W + UPC_W + CS_W + 3;
    localparam int DEPTH   = 32;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NCOND-1:0]  cond = '0;
    logic              prog_we = 1'b0;
    logic [UPC_W-1:0]  prog_addr = '0;
    logic [UI_W-1:0]   prog_data = '0;
    logic [CTRL_W-1:0] c;
    logic              busy;
    logic              done;
    logic              err;
    logic [UPC_W-1:0]  upc;

    always #5 clk = ~clk;

    microseq_ctrl #(
        .UPC_W(UPC_W), .CTRL_W(CTRL_W), .NCOND(NCOND),
        .STACK_D(STACK_D), .START_ADDR(START)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cond(cond),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .c(c), .busy(busy), .done(done), .err(err), .upc(upc)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [CTRL_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Interpreter over the instruction set: a word array for the store and
    // a queue for the return stack.
    logic [UI_W-1:0] m_mem [DEPTH];
    bit  m_run = 0;
    int  m_upc = START;
    bit  m_done = 0;
    bit  m_err = 0;
    int  m_stack[$];

    function automatic logic [UI_W-1:0] mk(input int op, input int inv, input int sel,
                                           input int tgt, input int ctrl);
        int w;
        w = (op << (UI_W - 2)) + (inv << (CTRL_W + UPC_W + CS_W))
          + (sel << (CTRL_W + UPC_W)) + (tgt << CTRL_W) + ctrl;
        return UI_W'(w);
    endfunction

    function automatic logic [CTRL_W-1:0] exp_c();
        int w;
        if (!m_run) return '0;
        w = int'(m_mem[m_upc]);
        return CTRL_W'(w % (1 << CTRL_W));
    endfunction

    task automatic model_step(input bit st, input bit we, input int addr,
                              input logic [UI_W-1:0] data, input bit rst,
                              input logic [NCOND-1:0] cv);
        bit was_run;
        int w, op, inv, sel, tgt, nxt;
        bit selv, br;
        was_run = m_run;
        if (rst) begin
            m_run = 0; m_upc = START; m_done = 0; m_err = 0; m_stack.delete();
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_upc = START; m_done = 0; m_err = 0; m_stack.delete();
            end
        end else begin
            w   = int'(m_mem[m_upc]);
            tgt = (w >> CTRL_W) % DEPTH;
            sel = (w >> (CTRL_W + UPC_W)) % (1 << CS_W);
            inv = (w >> (CTRL_W + UPC_W + CS_W)) % 2;
            op  = w >> (UI_W - 2);
            if (sel == 1) selv = 1;
            else if (sel >= 2 && sel - 2 < NCOND) selv = cv[sel - 2];
            else selv = 0;
            br  = selv ^ bit'(inv);
            nxt = (m_upc + 1) % DEPTH;
            case (op)
                0: m_upc = br ? tgt : nxt;
                1: if (!br) m_upc = nxt;
                   else if (m_stack.size() >= STACK_D) begin m_err = 1; m_run = 0; end
                   else begin m_stack.push_back(nxt); m_upc = tgt; end
                2: if (!br) m_upc = nxt;
                   else if (m_stack.size() == 0) begin m_err = 1; m_run = 0; end
                   else m_upc = m_stack.pop_back();
                default: if (!br) m_upc = nxt;
                         else begin m_run = 0; m_done = 1; end
            endcase
        end
        if (we && !was_run) m_mem[addr] = data;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit st, input bit we, input int addr,
                        input logic [UI_W-1:0] data, input bit rst,
                        input logic [NCOND-1:0] cv);
        @(negedge clk);
        start = st; prog_we = we; prog_addr = UPC_W'(addr);
        prog_data = data; reset = rst; cond = cv;
        model_step(st, we, addr, data, rst, cv);
        exp_q.push_back(exp_c());
        @(posedge clk);
        #1;
        chk("c", 32'(c), 32'(exp_q.pop_front()));
        chk("busy", 32'(busy), 32'(m_run));
        chk("upc", 32'(upc), 32'(m_upc));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic prog(input int addr, input logic [UI_W-1:0] data);
        step(0, 1, addr, data, 0, '0);
    endtask

    task automatic cyc(input logic [NCOND-1:0] cv);
        step(0, 0, 0, '0, 0, cv);
    endtask

    task automatic go(input logic [NCOND-1:0] cv);
        step(1, 0, 0, '0, 0, cv);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        step(0, 0, 0, '0, 1, '0);
        step(0, 0, 0, '0, 1, '0);
        chk("reset_upc", 32'(upc), START);
        chk("reset_busy", 32'(busy), 0);

        // Fill the store with taken HALTs so every address is defined.
        for (int i = 0; i < DEPTH; i++) prog(i, mk(3, 0, 1, 0, 0));

        // 1: JMP then HALT
        prog(0, mk(0, 0, 1, 5, 'h0001));
        prog(5, mk(3, 0, 1, 0, 'h4000));
        go('0);
        chk("t1_c1", 32'(c), 'h0001);
        cyc('0);
        chk("t1_c2", 32'(c), 'h4000);
        cyc('0);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_upc", 32'(upc), 5);

        // 2: wait loop on inverted cond[0]
        prog(0, mk(0, 1, 2, 0, 'h0010));
        prog(1, mk(3, 0, 1, 0, 'h0020));
        go('0);
        for (int i = 0; i < 3; i++) cyc(4'b0000);
        chk("t2_hold", 32'(upc), 0);
        cyc(4'b0001);
        chk("t2_move", 32'(upc), 1);
        chk("t2_notdone", 32'(done), 0);
        cyc(4'b0001);
        chk("t2_done", 32'(done), 1);

        // 3: CALL / RET
        prog(0, mk(1, 0, 1, 10, 'h0011));
        prog(10, mk(2, 0, 1, 0, 'h0022));
        prog(1, mk(3, 0, 1, 0, 'h0033));
        go('0);
        cyc('0);
        chk("t3_sub", 32'(upc), 10);
        cyc('0);
        chk("t3_ret", 32'(upc), 1);
        cyc('0);
        chk("t3_done", 32'(done), 1);
        chk("t3_err", 32'(err), 0);

        // 4: stack overflow, then underflow
        prog(0, mk(1, 0, 1, 1, 'h0101));
        prog(1, mk(1, 0, 1, 2, 'h0102));
        prog(2, mk(1, 0, 1, 3, 'h0103));
        go('0);
        cyc('0);
        cyc('0);
        cyc('0);
        chk("t4_ovf_err", 32'(err), 1);
        chk("t4_ovf_busy", 32'(busy), 0);
        chk("t4_ovf_done", 32'(done), 0);
        prog(0, mk(2, 0, 1, 0, 'h0104));
        go('0);
        chk("t4_err_cleared", 32'(err), 0);
        cyc('0);
        chk("t4_unf_err", 32'(err), 1);

        // 5: reset mid-run, and writes while busy are ignored
        for (int i = 0; i < 9; i++) prog(i, mk(0, 0, 0, 0, i + 1));
        prog(9, mk(3, 0, 1, 0, 'h0200));
        go('0);
        cyc('0);
        step(0, 1, 8, mk(3, 0, 1, 0, 'h7777), 0, '0);
        for (int i = 0; i < 5; i++) cyc('0);
        chk("t5_at7", 32'(upc), 7);
        step(0, 0, 0, '0, 1, '0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_upc", 32'(upc), START);
        go('0);
        for (int i = 0; i < 8; i++) cyc('0);
        chk("t5_kept", 32'(c), 9);
        cyc('0);
        cyc('0);
        chk("t5_done", 32'(done), 1);

        // 6: wrap and out-of-range select
        prog(0, mk(0, 0, 3, 30, 'h0300));
        prog(30, mk(0, 0, 0, 0, 'h0301));
        prog(31, mk(0, 0, 0, 0, 'h0302));
        prog(1, mk(3, 1, NCOND + 2, 0, 'h0303));
        go(4'b0010);
        cyc(4'b0010);
        cyc(4'b0010);
        cyc(4'b0010);
        chk("t6_wrap", 32'(upc), 0);
        cyc(4'b0000);
        cyc(4'b0000);
        chk("t6_oor_done", 32'(done), 1);

        // 7: write and start in the same idle cycle
        step(1, 1, 0, mk(3, 0, 1, 0, 'h0055), 0, '0);
        chk("t7_new_word", 32'(c), 'h0055);
        cyc('0);

        // Random programs with noise on start/prog_we while busy
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < DEPTH; a++)
                prog(a, mk($urandom_range(0, 3), $urandom_range(0, 1),
                           $urandom_range(0, 7), $urandom_range(0, DEPTH - 1),
                           $urandom_range(0, (1 << CTRL_W) - 1)));
            go(4'($urandom_range(0, 15)));
            n = 0;
            while (m_run && n < 40) begin
                step($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                     $urandom_range(0, DEPTH - 1), UI_W'($urandom),
                     $urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)));
                n++;
            end
            if (m_run) step(0, 0, 0, '0, 1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
